// File: rtl/act_pwq_unit.sv
// act_pwq_unit: piecewise-quadratic activation (sigmoid / tanh / ReLU) with
// a writable coefficient/threshold table and a 4-stage valid-tagged pipeline.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset (restores table)
//   en               pipeline advance; 0 freezes every pipeline register
//   in_valid, a      input sample and its valid flag (signed Q(WIDTH-FL).FL)
//   mode             00 sigmoid, 01 tanh, 10 ReLU (if compiled), 11 sigmoid
//   cfg_we/addr/data table write port, active regardless of en
//   out_valid, y     result and its valid flag, 4 en-cycles after input
//
// Optional feature macro: ACT_RELU_EN (compiles the ReLU leg for mode 10;
// without it mode 10 evaluates as sigmoid).

module act_pwq_unit #(
    parameter int WIDTH = 32,
    parameter int FL    = 24,
    parameter int NSEG  = 4,
    parameter int AW    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] a,
    input  logic [1:0]              mode,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [WIDTH-1:0]        cfg_data,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] y
);

    localparam int SW = $clog2(NSEG);

    localparam logic signed [WIDTH-1:0] ONE =
        {{(WIDTH-1){1'b0}}, 1'b1} << FL;
    localparam logic signed [WIDTH-1:0] MAXP =
        {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MINN =
        {1'b1, {(WIDTH-1){1'b0}}};

    // Reset table: the four-segment sigmoid fit; other sizes reset to zero.
    function automatic logic signed [WIDTH-1:0] rv_c2(input int k);
        rv_c2 = '0;
        if (NSEG == 4) begin
            case (k)
                0: rv_c2 = WIDTH'(32'hFFF69FE0);
                1: rv_c2 = WIDTH'(32'hFFF852B5);
                2: rv_c2 = WIDTH'(32'hFFFED1F2);
                default: rv_c2 = '0;
            endcase
        end
    endfunction

    function automatic logic signed [WIDTH-1:0] rv_c1(input int k);
        rv_c1 = '0;
        if (NSEG == 4) begin
            case (k)
                0: rv_c1 = WIDTH'(32'h0044E38A);
                1: rv_c1 = WIDTH'(32'h0039569F);
                2: rv_c1 = WIDTH'(32'h000DB91F);
                default: rv_c1 = '0;
            endcase
        end
    endfunction

    function automatic logic signed [WIDTH-1:0] rv_c0(input int k);
        rv_c0 = '0;
        if (NSEG == 4) begin
            case (k)
                0: rv_c0 = WIDTH'(32'h007F7143);
                1: rv_c0 = WIDTH'(32'h008D387A);
                2: rv_c0 = WIDTH'(32'h00D7418D);
                default: rv_c0 = ONE;
            endcase
        end
    endfunction

    function automatic logic signed [WIDTH-1:0] rv_th(input int j);
        rv_th = '0;
        if (NSEG == 4) begin
            case (j)
                0: rv_th = WIDTH'(32'h01800000);
                1: rv_th = WIDTH'(32'h03800000);
                default: rv_th = WIDTH'(32'h06000000);
            endcase
        end
    endfunction

    // ---------------- table ----------------
    logic signed [WIDTH-1:0] c2_q [NSEG];
    logic signed [WIDTH-1:0] c1_q [NSEG];
    logic signed [WIDTH-1:0] c0_q [NSEG];
    logic signed [WIDTH-1:0] th_q [NSEG-1];
    logic signed [WIDTH-1:0] c2_d [NSEG];
    logic signed [WIDTH-1:0] c1_d [NSEG];
    logic signed [WIDTH-1:0] c0_d [NSEG];
    logic signed [WIDTH-1:0] th_d [NSEG-1];

    always_comb begin
        c2_d = c2_q;
        c1_d = c1_q;
        c0_d = c0_q;
        th_d = th_q;
        if (cfg_we) begin
            for (int k = 0; k < NSEG; k++) begin
                if (cfg_addr == AW'(k))
                    c2_d[k] = cfg_data;
                if (cfg_addr == AW'(NSEG + k))
                    c1_d[k] = cfg_data;
                if (cfg_addr == AW'(2 * NSEG + k))
                    c0_d[k] = cfg_data;
            end
            for (int j = 0; j < NSEG - 1; j++) begin
                if (cfg_addr == AW'(3 * NSEG + j))
                    th_d[j] = cfg_data;
            end
        end
    end

    // ---------------- S1 select ----------------
    logic signed [WIDTH-1:0] a_abs;
    logic [SW-1:0]           seg;

    always_comb begin
        if (!a[WIDTH-1])
            a_abs = a;
        else if (a == MINN)
            a_abs = MAXP;
        else
            a_abs = -a;
        // Count of thresholds passed; order of the table is not checked.
        seg = '0;
        for (int j = 0; j < NSEG - 1; j++) begin
            if (th_q[j] <= a_abs)
                seg = seg + SW'(1);
        end
    end

    // ---------------- pipeline state ----------------
    logic                    v1_q, v2_q, v3_q, ov_q;
    logic                    v1_d, v2_d, v3_d, ov_d;
    logic                    sg1_q, sg2_q, sg3_q;
    logic                    sg1_d, sg2_d, sg3_d;
    logic                    th1_q, th2_q, th3_q;
    logic                    th1_d, th2_d, th3_d;
    logic signed [WIDTH-1:0] abs1_q, c2_1_q, c1_1_q, c0_1_q;
    logic signed [WIDTH-1:0] abs1_d, c2_1_d, c1_1_d, c0_1_d;
    logic signed [WIDTH-1:0] sq2_q, t1_2_q, c2_2_q, c0_2_q;
    logic signed [WIDTH-1:0] sq2_d, t1_2_d, c2_2_d, c0_2_d;
    logic signed [WIDTH-1:0] t2_3_q, s3_q;
    logic signed [WIDTH-1:0] t2_3_d, s3_d;
    logic signed [WIDTH-1:0] y_q, y_d;
`ifdef ACT_RELU_EN
    logic                    rl1_q, rl2_q, rl3_q;
    logic                    rl1_d, rl2_d, rl3_d;
    logic signed [WIDTH-1:0] a1_q, a2_q, a3_q;
    logic signed [WIDTH-1:0] a1_d, a2_d, a3_d;
`endif

    logic signed [2*WIDTH-1:0] p_sq, p_t1, p_t2;
    logic signed [WIDTH-1:0]   ysum, yabs;

    always_comb begin
        p_sq = abs1_q * abs1_q;
        p_t1 = c1_1_q * abs1_q;
        p_t2 = c2_2_q * sq2_q;
        ysum = t2_3_q + s3_q;
        if (ysum[WIDTH-1])
            yabs = '0;
        else if (ysum > ONE)
            yabs = ONE;
        else
            yabs = ysum;
    end

    always_comb begin
        v1_d = v1_q;   sg1_d = sg1_q;   th1_d = th1_q;
        abs1_d = abs1_q;
        c2_1_d = c2_1_q; c1_1_d = c1_1_q; c0_1_d = c0_1_q;
        v2_d = v2_q;   sg2_d = sg2_q;   th2_d = th2_q;
        sq2_d = sq2_q; t1_2_d = t1_2_q;
        c2_2_d = c2_2_q; c0_2_d = c0_2_q;
        v3_d = v3_q;   sg3_d = sg3_q;   th3_d = th3_q;
        t2_3_d = t2_3_q; s3_d = s3_q;
        ov_d = ov_q;   y_d = y_q;
`ifdef ACT_RELU_EN
        rl1_d = rl1_q; rl2_d = rl2_q; rl3_d = rl3_q;
        a1_d = a1_q;   a2_d = a2_q;   a3_d = a3_q;
`endif
        if (en) begin
            // S1: the table is read before any same-cycle write lands.
            v1_d   = in_valid;
            sg1_d  = a[WIDTH-1];
            th1_d  = (mode == 2'b01);
            abs1_d = a_abs;
            c2_1_d = c2_q[seg];
            c1_1_d = c1_q[seg];
            c0_1_d = c0_q[seg];
            // S2: products keep bits [FL+WIDTH-1:FL] by truncation.
            v2_d   = v1_q;
            sg2_d  = sg1_q;
            th2_d  = th1_q;
            sq2_d  = WIDTH'(p_sq >>> FL);
            t1_2_d = WIDTH'(p_t1 >>> FL);
            c2_2_d = c2_1_q;
            c0_2_d = c0_1_q;
            // S3
            v3_d   = v2_q;
            sg3_d  = sg2_q;
            th3_d  = th2_q;
            t2_3_d = WIDTH'(p_t2 >>> FL);
            s3_d   = t1_2_q + c0_2_q;
            // S4: symmetry around the clamped |a| result.
            ov_d   = v3_q;
            if (th3_q)
                y_d = sg3_q ? -yabs : yabs;
            else
                y_d = sg3_q ? ONE - yabs : yabs;
`ifdef ACT_RELU_EN
            rl1_d = (mode == 2'b10);
            rl2_d = rl1_q;
            rl3_d = rl2_q;
            a1_d  = a;
            a2_d  = a1_q;
            a3_d  = a2_q;
            if (rl3_q)
                y_d = sg3_q ? '0 : a3_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                c2_q[k] <= rv_c2(k);
                c1_q[k] <= rv_c1(k);
                c0_q[k] <= rv_c0(k);
            end
            for (int j = 0; j < NSEG - 1; j++)
                th_q[j] <= rv_th(j);
            v1_q <= 1'b0; sg1_q <= 1'b0; th1_q <= 1'b0;
            abs1_q <= '0;
            c2_1_q <= '0; c1_1_q <= '0; c0_1_q <= '0;
            v2_q <= 1'b0; sg2_q <= 1'b0; th2_q <= 1'b0;
            sq2_q <= '0; t1_2_q <= '0;
            c2_2_q <= '0; c0_2_q <= '0;
            v3_q <= 1'b0; sg3_q <= 1'b0; th3_q <= 1'b0;
            t2_3_q <= '0; s3_q <= '0;
            ov_q <= 1'b0; y_q <= '0;
`ifdef ACT_RELU_EN
            rl1_q <= 1'b0; rl2_q <= 1'b0; rl3_q <= 1'b0;
            a1_q <= '0; a2_q <= '0; a3_q <= '0;
`endif
        end else begin
            c2_q <= c2_d;
            c1_q <= c1_d;
            c0_q <= c0_d;
            th_q <= th_d;
            v1_q <= v1_d; sg1_q <= sg1_d; th1_q <= th1_d;
            abs1_q <= abs1_d;
            c2_1_q <= c2_1_d; c1_1_q <= c1_1_d; c0_1_q <= c0_1_d;
            v2_q <= v2_d; sg2_q <= sg2_d; th2_q <= th2_d;
            sq2_q <= sq2_d; t1_2_q <= t1_2_d;
            c2_2_q <= c2_2_d; c0_2_q <= c0_2_d;
            v3_q <= v3_d; sg3_q <= sg3_d; th3_q <= th3_d;
            t2_3_q <= t2_3_d; s3_q <= s3_d;
            ov_q <= ov_d; y_q <= y_d;
`ifdef ACT_RELU_EN
            rl1_q <= rl1_d; rl2_q <= rl2_d; rl3_q <= rl3_d;
            a1_q <= a1_d; a2_q <= a2_d; a3_q <= a3_d;
`endif
        end
    end

    assign out_valid = ov_q;
    assign y         = y_q;

endmodule

// File: tb/tb_act_pwq_unit.sv
// Directed bench for act_pwq_unit: latency, symmetry modes, thresholds,
// en freeze, table writes, clamping and reset flush.

module tb_act_pwq_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               in_valid;
    logic signed [31:0] a;
    logic [1:0]         mode;
    logic               cfg_we;
    logic [5:0]         cfg_addr;
    logic [31:0]        cfg_data;
    logic               out_valid;
    logic signed [31:0] y;

    int checks = 0;
    int errors = 0;
    logic [31:0] ypos;
    logic [31:0] ysum;

    act_pwq_unit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .mode      (mode),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [31:0] av, input logic [1:0] m,
                           input logic [31:0] exp, input string tag);
        a        = av;
        mode     = m;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
        chk(tag, y, exp);
    endtask

    task automatic wr(input logic [5:0] ad, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = ad;
        cfg_data = d;
        cyc();
        cfg_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; a = '0; mode = 2'b00;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        cyc();
        cyc();
        chk("rst_y", y, 32'h0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        rst = 1'b0;

        // Latency: one pulse, visible after exactly four edges.
        a = 32'h0; mode = 2'b00; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("lat_e1", 32'(out_valid), 32'd0);
        cyc();
        chk("lat_e2", 32'(out_valid), 32'd0);
        cyc();
        chk("lat_e3", 32'(out_valid), 32'd0);
        cyc();
        chk("lat_ov", 32'(out_valid), 32'd1);
        chk("lat_y", y, 32'h007F7143);
        cyc();
        chk("lat_off", 32'(out_valid), 32'd0);

        run_one(32'h08000000, 2'b00, 32'h01000000, "sig_p8");
        run_one(32'hF8000000, 2'b00, 32'h00000000, "sig_n8");
        run_one(32'hF8000000, 2'b01, 32'hFF000000, "tanh_n8");
        run_one(32'h80000000, 2'b01, 32'hFF000000, "tanh_min");
        run_one(32'h06000000, 2'b00, 32'h01000000, "th_edge");
        run_one(32'h00000000, 2'b11, 32'h007F7143, "mode3");

        // +1.0 / -1.0 back to back: seg0 gives c2+c1+c0 = 0x00BAF4AD.
        a = 32'h01000000; mode = 2'b00; in_valid = 1'b1;
        cyc();
        a = 32'hFF000000;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("b2b_ov0", 32'(out_valid), 32'd1);
        chk("b2b_pos", y, 32'h00BAF4AD);
        ypos = y;
        cyc();
        chk("b2b_ov1", 32'(out_valid), 32'd1);
        chk("b2b_neg", y, 32'h00450B53);
        ysum = ypos + y;
        chk("b2b_sum",
            32'((ysum >= 32'h00FFFFFF) && (ysum <= 32'h01000001)), 32'd1);

        // en freeze with three samples in flight.
        a = 32'h00000000; in_valid = 1'b1;
        cyc();
        a = 32'h08000000;
        cyc();
        a = 32'hF8000000;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("frz_a_ov", 32'(out_valid), 32'd1);
        chk("frz_a_y", y, 32'h007F7143);
        en = 1'b0; in_valid = 1'b1; a = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("frz_hold_ov", 32'(out_valid), 32'd1);
            chk("frz_hold_y", y, 32'h007F7143);
        end
        in_valid = 1'b0; en = 1'b1;
        cyc();
        chk("frz_b_ov", 32'(out_valid), 32'd1);
        chk("frz_b_y", y, 32'h01000000);
        cyc();
        chk("frz_c_ov", 32'(out_valid), 32'd1);
        chk("frz_c_y", y, 32'h00000000);
        cyc();
        chk("frz_end", 32'(out_valid), 32'd0);

        // Table write; the sample in the c0 write cycle sees the old c0.
        wr(6'd0, 32'h0);
        wr(6'd4, 32'h0);
        cfg_we = 1'b1; cfg_addr = 6'd8; cfg_data = 32'h00400000;
        a = 32'h00800000; mode = 2'b00; in_valid = 1'b1;
        cyc();
        cfg_we = 1'b0;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("wr_old_ov", 32'(out_valid), 32'd1);
        chk("wr_old_y", y, 32'h007F7143);
        cyc();
        chk("wr_new_ov", 32'(out_valid), 32'd1);
        chk("wr_new_y", y, 32'h00400000);

        // Clamp to [0, ONE].
        wr(6'd8, 32'h02000000);
        run_one(32'h0, 2'b00, 32'h01000000, "clamp_hi");
        wr(6'd8, 32'hFF000000);
        run_one(32'h0, 2'b00, 32'h00000000, "clamp_lo");

        // Reset with three samples in flight.
        a = 32'h0; in_valid = 1'b1;
        cyc();
        cyc();
        cyc();
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("flush_y", y, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("flush_ov", 32'(out_valid), 32'd0);
            cyc();
        end
        run_one(32'h0, 2'b00, 32'h007F7143, "rst_table");

`ifdef ACT_RELU_EN
        run_one(32'hFF800000, 2'b10, 32'h00000000, "relu_neg");
        run_one(32'h02000000, 2'b10, 32'h02000000, "relu_pos");
`else
        run_one(32'h00000000, 2'b10, 32'h007F7143, "mode2_sig");
        run_one(32'hF8000000, 2'b10, 32'h00000000, "mode2_neg");
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
